filter_loader: RTL and testbench
================================

Name: filter_loader

Overview:
- Write-side controller for the PE filter buffer: the producer of the 4-lane data bus and 16-bit entry write-enable that the PE filter buffer consumes.
- On a start pulse, it fetches a kernel of 1..16 byte entries from filter memory, one 4-byte word per read, and writes each word into buffer entries 4k..4k+3.
- Sits between the filter SRAM and one or more PE filter buffers.
- Pulses done once the last entry is written, so the PE sequencer can begin MAC passes.

Parameters:
- DATA_W, 8, bits per filter entry.
- LANES, 4, entries delivered per memory word / buffer write.
- DEPTH, 16, filter buffer entries; must equal LANES*WORDS_MAX.
- ADDR_W, 8, filter memory word-address width.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_W  word address of kernel word 0; captured on an accepted start.
- filter_len  input  5  number of entries to load (0..16); captured on an accepted start.
- hold  input  1  stall; while high, no new memory read is issued.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory word address.
- mem_rdata  input  DATA_W x LANES (unpacked [0:3])  read data; valid exactly 1 cycle after mem_rd_en.
- buf_data  output  DATA_W x LANES (unpacked [0:3])  lane data to the filter buffer dataIn.
- buf_en  output  DEPTH  per-entry write enable to the filter buffer.
- busy  output  1  load in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - State -> IDLE.
  - mem_rd_en=0, mem_addr=0, buf_en=0, buf_data=all 0, busy=0, done=0.
  - Applies mid-load: any in-flight read is discarded and no buf_en is issued afterwards.
- Word count: words = ceil(filter_len/4), computed from the captured length.
  - Last-word lane mask: lanes 0..((filter_len-1) mod 4) enabled; all 4 lanes for full words.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start, capture base_addr and filter_len.
  - len=0 -> DONE.
  - Otherwise -> READ. Word counter rd_k=0; busy=1 from the next cycle.
- READ (issue stage):
  - Each cycle with hold=0: mem_rd_en=1, mem_addr=base+rd_k, rd_k++.
  - After issuing the last word -> DRAIN.
  - hold=1: mem_rd_en=0, rd_k unchanged, stay in READ.
- Write stage (pipelined, independent of state):
  - A registered copy of mem_rd_en, with word index wr_k and lane mask, follows each read by 1 cycle.
  - In that cycle: buf_data=mem_rdata passed combinationally; buf_en bits 4*wr_k+i set for each enabled lane i; all other bits 0.
  - Back-to-back reads give back-to-back writes.
  - hold never suppresses a write whose read has already issued.
- DRAIN: wait one cycle for the final write, then -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then -> IDLE.
- Latency (no hold, N words, start sampled at cycle 0):
  - Reads at cycles 1..N.
  - Writes at cycles 2..N+1.
  - done at cycle N+2.
  - busy high for cycles 1..N+1.
  - len=0: done at cycle 1, busy never set.
- start while busy or in DONE is ignored; no queuing.
- Address arithmetic wraps modulo 2^ADDR_W.
- filter_len > 16 is clamped to 16.
- buf_en is 0 in every cycle without a write.
- buf_data equals mem_rdata only during write cycles; otherwise it is 0.

Decomposition:
- Shared package (filter_pkg):
  - DATA_W, LANES, DEPTH.
  - State enum {IDLE, READ, DRAIN, DONE}.
  - Lane-mask function from the length remainder.
- One natural sub-module: filter_wr_stage, the 1-cycle write-stage register plus the buf_en decoder (wr_k, mask -> 16-bit one-hot-group enable).

Test Plan:
- len=16, base=0x20, hold=0 -> reads 0x20..0x23 at cycles 1..4; buf_en 0x000F,0x00F0,0x0F00,0xF000 at cycles 2..5 with matching data; done at cycle 6.
- len=9, base=0x40 -> 3 reads (0x40..0x42); buf_en 0x000F,0x00F0,0x0100; done at cycle 5.
- len=0 -> no mem_rd_en, buf_en always 0, busy stays 0, done pulses at cycle 1.
- len=16 with hold=1 during cycles 2-3 -> reads at cycles 1,4,5,6; write at cycle 2 still occurs (in-flight); writes at 5,6,7; done at cycle 8.
- rst asserted at cycle 3 of a len=16 load -> buf_en 0 from cycle 4 on (cycle-3 read data never written); busy=0; no done; next start behaves as from reset.
- start re-pulsed at cycle 2 during a load, with a different base -> ignored; original address sequence and done timing unchanged.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: shared constants, FSM state type and lane-mask helper for the filter loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package filter_pkg;

  localparam int DATA_W    = 8;               // bits per filter entry
  localparam int LANES     = 4;               // entries per memory word / buffer write
  localparam int WORDS_MAX = 4;               // words in a full kernel
  localparam int DEPTH     = LANES * WORDS_MAX;
  localparam int LEN_W     = 5;               // filter_len width (0..16, larger clamped)
  localparam int K_W       = 2;               // word index width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Lanes enabled in the last word, from filter_len mod 4.
  // A remainder of 0 means the last word is full.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] rem);
    case (rem)
      2'd1:    lane_mask = 4'b0001;
      2'd2:    lane_mask = 4'b0011;
      2'd3:    lane_mask = 4'b0111;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/filter_wr_stage.sv
// filter_wr_stage: write-stage register and buf_en decoder for the filter buffer.
// Latency: write happens exactly 1 cycle after its read strobe; data passes combinationally.
// Backpressure: none; every issued read produces a write on the following cycle.
//
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   rd_vld          read strobe issued this cycle
//   rd_k, rd_mask   word index and lane mask of that read
//   mem_rdata       memory data, valid the cycle after rd_vld
//   buf_data        lane data to the filter buffer (0 outside write cycles)
//   buf_en          per-entry write enable (bits 4*k+i for enabled lanes i)
module filter_wr_stage
  import filter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_vld,
  input  logic [K_W-1:0]    rd_k,
  input  logic [LANES-1:0]  rd_mask,
  input  logic [DATA_W-1:0] mem_rdata [0:LANES-1],
  output logic [DATA_W-1:0] buf_data  [0:LANES-1],
  output logic [DEPTH-1:0]  buf_en
);

  logic             wr_vld_q;
  logic [K_W-1:0]   wr_k_q;
  logic [LANES-1:0] wr_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q  <= 1'b0;
      wr_k_q    <= '0;
      wr_mask_q <= '0;
    end else begin
      wr_vld_q  <= rd_vld;
      wr_k_q    <= rd_k;
      wr_mask_q <= rd_mask;
    end
  end

  always_comb begin
    buf_en = '0;
    if (wr_vld_q) begin
      // Place the lane mask on the entry group of word wr_k.
      buf_en = DEPTH'(wr_mask_q) << (wr_k_q * LANES);
    end
    for (int i = 0; i < LANES; i++) begin
      buf_data[i] = wr_vld_q ? mem_rdata[i] : '0;
    end
  end

endmodule

// File: rtl/filter_loader.sv
// filter_loader: fetches a 1..16 entry kernel from filter memory and writes it into the PE filter buffer.
// Latency: N words -> reads cycles 1..N, writes 2..N+1, done at N+2 after start; len=0 -> done at 1.
// Backpressure: hold=1 suppresses new reads only; reads already issued are always written.
//
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   start, base_addr,        load request with kernel word address and entry count,
//   filter_len               captured only in IDLE
//   hold                     stall read issue
//   mem_rd_en, mem_addr      filter memory read port (data returns one cycle later on mem_rdata)
//   buf_data, buf_en         filter buffer write port
//   busy, done               load in progress / one-cycle completion pulse
module filter_loader
  import filter_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  filter_len,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata [0:LANES-1],
  output logic [DATA_W-1:0] buf_data  [0:LANES-1],
  output logic [DEPTH-1:0]  buf_en,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [K_W-1:0]    rd_k_q;
  logic [K_W-1:0]    last_k_q;  // index of the final word
  logic [1:0]        rem_q;     // entries mod 4, selects the last-word mask

  logic [LEN_W-1:0]  len_c;
  logic [K_W-1:0]    last_k_c;
  logic [LANES-1:0]  rd_mask;

  // Lengths above the buffer depth load the whole buffer.
  assign len_c    = (filter_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : filter_len;
  // ceil(len/4)-1; meaningless for len=0, which never enters READ.
  assign last_k_c = K_W'((len_c - LEN_W'(1)) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      rd_k_q   <= '0;
      last_k_q <= '0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            rd_k_q   <= '0;
            last_k_q <= last_k_c;
            rem_q    <= len_c[1:0];
            state_q  <= (len_c == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (!hold) begin
            rd_k_q <= rd_k_q + K_W'(1);
            if (rd_k_q == last_k_q) state_q <= DRAIN;
          end
        end
        // One cycle for the final write to land in the buffer.
        DRAIN:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read issue reacts to hold in the same cycle so a stall never wastes a slot.
  assign mem_rd_en = (state_q == READ) && !hold;
  assign mem_addr  = mem_rd_en ? (base_q + ADDR_W'(rd_k_q)) : '0;
  assign rd_mask   = (rd_k_q == last_k_q) ? lane_mask(rem_q) : {LANES{1'b1}};
  assign busy      = (state_q == READ) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  filter_wr_stage u_wr_stage (
    .clk       (clk),
    .rst       (rst),
    .rd_vld    (mem_rd_en),
    .rd_k      (rd_k_q),
    .rd_mask   (rd_mask),
    .mem_rdata (mem_rdata),
    .buf_data  (buf_data),
    .buf_en    (buf_en)
  );

endmodule

// File: tb/tb_filter_loader.sv
// tb_filter_loader: directed per-cycle checks of filter_loader against hand-written expectations.
// Inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// The memory model returns data one cycle after a read; idle cycles return 8'hEE to expose ungated data.
module tb_filter_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [4:0] filter_len;
  logic       hold;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata [0:3];
  logic [7:0] buf_data  [0:3];
  logic [15:0] buf_en;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  int cycno = 0;

  filter_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .filter_len (filter_len),
    .hold       (hold),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .buf_data   (buf_data),
    .buf_en     (buf_en),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: lane i of word a holds a + 64*i.
  function automatic logic [7:0] dat(input logic [7:0] a, input int i);
    logic [7:0] off;
    off = 8'(64 * i);
    return a + off;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      mem_rdata[i] <= (mem_rd_en === 1'b1) ? dat(mem_addr, i) : 8'hEE;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cycno, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance.
  // e_wa is the memory address whose data must appear on buf_data when e_en != 0.
  task automatic cyc(input logic s, input logic [7:0] b, input logic [4:0] l,
                     input logic h, input logic r,
                     input logic e_rd, input logic [7:0] e_addr, input logic [15:0] e_en,
                     input logic [7:0] e_wa, input logic e_busy, input logic e_done);
    logic [31:0] exp_d;
    start = s; base_addr = b; filter_len = l; hold = h; rst = r;
    @(negedge clk);
    check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    if (e_rd) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("buf_en", 32'(buf_en), 32'(e_en));
    exp_d = (e_en != 16'h0) ? {dat(e_wa, 0), dat(e_wa, 1), dat(e_wa, 2), dat(e_wa, 3)} : 32'h0;
    check("buf_data", {buf_data[0], buf_data[1], buf_data[2], buf_data[3]}, exp_d);
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    @(posedge clk);
    #1;
    cycno++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 8'h0; filter_len = 5'd0; hold = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    #1;
    //  s  base   len  h  r   rd addr   en        wa     busy done
    cyc(0, 8'h00, 0,   0, 1,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    // len=16, base 0x20
    cyc(1, 8'h20, 16,  0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h20, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h21, 16'h000F, 8'h20, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h22, 16'h00F0, 8'h21, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h23, 16'h0F00, 8'h22, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'hF000, 8'h23, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    // len=9, base 0x40: partial last word, one lane
    cyc(1, 8'h40, 9,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h40, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h41, 16'h000F, 8'h40, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h42, 16'h00F0, 8'h41, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0100, 8'h42, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);

    // len=0: done at cycle 1, never busy
    cyc(1, 8'h33, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    // len=16, base 0x80, hold during cycles 2-3
    cyc(1, 8'h80, 16,  0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h80, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   1, 0,  0, 8'h00, 16'h000F, 8'h80, 1, 0);
    cyc(0, 8'h00, 0,   1, 0,  0, 8'h00, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h81, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h82, 16'h00F0, 8'h81, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h83, 16'h0F00, 8'h82, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'hF000, 8'h83, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    // len=16, base 0x10, reset during cycle 3: cycle-3 read never written, no done
    cyc(1, 8'h10, 16,  0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h10, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h11, 16'h000F, 8'h10, 1, 0);
    cyc(0, 8'h00, 0,   0, 1,  1, 8'h12, 16'h00F0, 8'h11, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    // len=5, base 0xFF after reset: address wraps, last word has one lane
    cyc(1, 8'hFF, 5,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'hFF, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h00, 16'h000F, 8'hFF, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0010, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);

    // len=8, base 0x30; start re-pulsed while busy and in DONE is ignored
    cyc(1, 8'h30, 8,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h30, 16'h0000, 8'h00, 1, 0);
    cyc(1, 8'h60, 16,  0, 0,  1, 8'h31, 16'h000F, 8'h30, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h00F0, 8'h31, 1, 0);
    cyc(1, 8'h60, 16,  0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    // len=3, base 0x05: single partial word
    cyc(1, 8'h05, 3,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'h05, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0007, 8'h05, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);

    // len=31 clamps to 16, base 0xC0
    cyc(1, 8'hC0, 31,  0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'hC0, 16'h0000, 8'h00, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'hC1, 16'h000F, 8'hC0, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'hC2, 16'h00F0, 8'hC1, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  1, 8'hC3, 16'h0F00, 8'hC2, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'hF000, 8'hC3, 1, 0);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 1);
    cyc(0, 8'h00, 0,   0, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
